imm_encoder: RTL and testbench
==============================

Name: imm_encoder

Overview:
- Inverse of the operand-2 immediate decode: takes a 32-bit constant and searches for an ARM data-processing immediate encoding {rotate[3:0], imm8[7:0]}, where value = ROR(zero_ext(imm8), 2*rotate).
- Optionally retries on the bitwise complement, so the caller can fall back to MVN.
- Sits beside the instruction/constant path: it is used by the test-program loader and the self-check logic to build Shift_operand fields with imm=1.
- Iterative: checks one rotation per clock, with valid/ready handshakes on both sides.

Parameters:
- ALLOW_INVERT, 1: 1 = after the direct search fails, search ~value; 0 = report not-found after the direct search.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_value  input  32  constant to encode
- in_ready  output  1  block can accept a request
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_found  output  1  encoding exists
- out_inverted  output  1  encoding is for ~in_value (use MVN)
- out_shift_operand  output  12  {rotate[3:0], imm8[7:0]}; 12'h000 when not found

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; in_ready=1; out_valid=0; out_found=0; out_inverted=0; out_shift_operand=0; internal registers cleared. Reset during SEARCH or DONE aborts the request and discards it.
- States and transitions:
  - IDLE: in_ready=1. On in_valid&&in_ready at an edge: latch in_value into val_q, r=0, phase=DIRECT, go to SEARCH.
  - SEARCH: in_ready=0. Each cycle, compute cand = ROL(phase?~val_q:val_q, 2*r) combinationally.
    - If cand[31:8]==0: at the next edge, out_found=1, out_inverted=phase, out_shift_operand={r, cand[7:0]}, out_valid=1, go to DONE.
    - Else if r!=15: r<=r+1.
    - Else if phase==DIRECT and ALLOW_INVERT: phase<=INVERT, r<=0.
    - Else: out_found=0, out_inverted=0, out_shift_operand=0, out_valid=1, go to DONE.
  - DONE: outputs held stable while out_valid && !out_ready. On out_ready at an edge: out_valid<=0, go to IDLE. in_ready returns to 1 the following cycle; there is no same-cycle overlap.
- The smallest rotate wins; the direct phase has priority over the inverted phase.
- Latency, counted in edges from the accept edge to the edge where out_valid rises:
  - Direct match at rotate k: k+1.
  - Inverted match at rotate k: 17+k.
  - Not found: 16 when ALLOW_INVERT=0, 32 when ALLOW_INVERT=1.
- Rotation arithmetic is a 32-bit circular rotate by 2*r (0..30); no bits are lost. r is a 4-bit counter that never wraps past 15 within a phase.
- in_value 0 encodes as rotate 0, imm8 0, found, with latency 1.
- in_value is sampled only at the accept edge; later changes are ignored.
- out_ready is ignored outside DONE.

Test Plan:
- Reset, then in_value=32'h000000FF -> 1 edge after accept: out_valid=1, found=1, inverted=0, shift_operand=12'h0FF.
- in_value=32'hFF000000 -> latency 5: shift_operand=12'h4FF, found=1.
- in_value=32'h000003FC -> latency 16: shift_operand=12'hFFF (rotate 15, imm8 FF).
- in_value=32'hFFFFFF00, ALLOW_INVERT=1 -> latency 17: found=1, inverted=1, shift_operand=12'h0FF. With ALLOW_INVERT=0 -> latency 16: found=0, shift_operand=12'h000.
- in_value=32'h00000102 (odd rotation needed), ALLOW_INVERT=1 -> latency 32: found=0, inverted=0, shift_operand=12'h000.
- Handshake and reset:
  - Hold out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0 throughout; then out_ready=1 -> out_valid=0, in_ready=1 the next cycle.
  - Assert rst_n=0 mid-SEARCH -> all outputs reset immediately; the next request encodes correctly.

Source files
------------

// File: rtl/imm_encoder.sv
// imm_encoder: iterative search for an ARM data-processing immediate
// encoding {rotate[3:0], imm8[7:0]} of a 32-bit constant, where
// value = ROR(zero_ext(imm8), 2*rotate). Optionally retries on ~value
// so the caller can fall back to MVN. One rotation is tried per clock.
//
// Handshakes: a transfer happens on a rising edge where valid && ready
// are both high. in_valid/in_value are only sampled on such an edge;
// out_valid and the result fields stay stable until out_ready is seen.
module imm_encoder #(
    parameter logic ALLOW_INVERT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] in_value,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_found,
    output logic        out_inverted,
    output logic [11:0] out_shift_operand
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] val_q;
    logic [3:0]  r;
    logic        phase;      // 0 = direct value, 1 = inverted value

    logic [31:0] src;
    logic [5:0]  sh;
    logic [31:0] cand;
    logic        hit;

    // Candidate for this cycle: rotating left by 2*r undoes a ROR by 2*r,
    // so the value is encodable at rotate r iff the top 24 bits are zero.
    // A shift by 32 (when sh == 0) yields zero, leaving cand == src.
    always_comb begin
        src  = phase ? ~val_q : val_q;
        sh   = {1'b0, r, 1'b0};
        cand = (src << sh) | (src >> (6'd32 - sh));
        hit  = (cand[31:8] == 24'h0);
    end

    // Search FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            val_q             <= 32'h0;
            r                 <= 4'h0;
            phase             <= 1'b0;
            in_ready          <= 1'b1;
            out_valid         <= 1'b0;
            out_found         <= 1'b0;
            out_inverted      <= 1'b0;
            out_shift_operand <= 12'h000;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        val_q    <= in_value;
                        r        <= 4'h0;
                        phase    <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (hit) begin
                        out_found         <= 1'b1;
                        out_inverted      <= phase;
                        out_shift_operand <= {r, cand[7:0]};
                        out_valid         <= 1'b1;
                        state             <= DONE;
                    end else if (r != 4'hF) begin
                        r <= r + 4'h1;
                    end else if (!phase && ALLOW_INVERT) begin
                        phase <= 1'b1;
                        r     <= 4'h0;
                    end else begin
                        out_found         <= 1'b0;
                        out_inverted      <= 1'b0;
                        out_shift_operand <= 12'h000;
                        out_valid         <= 1'b1;
                        state             <= DONE;
                    end
                end
                DONE: begin
                    // in_ready rises together with the return to IDLE, so a
                    // new request can only be accepted on the following edge.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Testbench for imm_encoder: one instance with ALLOW_INVERT=1 and one with
// ALLOW_INVERT=0 share the request stream; results and latencies are
// compared against a brute-force search over all (rotate, imm8) pairs.
module tb_imm_encoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_value;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, out_found_a, out_inverted_a;
    logic [11:0] out_so_a;
    logic        in_ready_b, out_valid_b, out_found_b, out_inverted_b;
    logic [11:0] out_so_b;

    int n_checks;
    int n_errors;

    imm_encoder #(.ALLOW_INVERT(1'b1)) dut_a (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .in_value          (in_value),
        .in_ready          (in_ready_a),
        .out_valid         (out_valid_a),
        .out_ready         (out_ready),
        .out_found         (out_found_a),
        .out_inverted      (out_inverted_a),
        .out_shift_operand (out_so_a)
    );

    imm_encoder #(.ALLOW_INVERT(1'b0)) dut_b (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .in_value          (in_value),
        .in_ready          (in_ready_b),
        .out_valid         (out_valid_b),
        .out_ready         (out_ready),
        .out_found         (out_found_b),
        .out_inverted      (out_inverted_b),
        .out_shift_operand (out_so_b)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    // Reference: exhaustive search over rotate then imm8, direct phase first.
    task automatic model(input logic [31:0] v, input logic allow,
                         output logic f, output logic inv,
                         output logic [11:0] so, output int lat);
        f   = 1'b0;
        inv = 1'b0;
        so  = 12'h000;
        lat = allow ? 32 : 16;
        for (int p = 0; p < (allow ? 2 : 1); p++) begin
            logic [31:0] w;
            w = (p == 1) ? ~v : v;
            for (int rr = 0; rr < 16; rr++) begin
                for (int i = 0; i < 256; i++) begin
                    if (!f && ror32(32'(i), 2 * rr) == w) begin
                        f   = 1'b1;
                        inv = (p == 1);
                        so  = {4'(rr), 8'(i)};
                        lat = 16 * p + rr + 1;
                    end
                end
            end
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_value  = 32'h0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One request on both instances; optionally hold out_ready low after both finish.
    task automatic run_one(input logic [31:0] v, input int hold);
        logic f_a, i_a, f_b, i_b;
        logic [11:0] s_a, s_b;
        int el_a, el_b, lat_a, lat_b;
        model(v, 1'b1, f_a, i_a, s_a, el_a);
        model(v, 1'b0, f_b, i_b, s_b, el_b);
        check("in_ready_a_pre", 32'(in_ready_a), 32'd1);
        check("in_ready_b_pre", 32'(in_ready_b), 32'd1);
        in_value = v;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_value = $urandom;  // must be ignored after accept
        lat_a = 0;
        lat_b = 0;
        for (int n = 1; n <= 40 && (lat_a == 0 || lat_b == 0); n++) begin
            @(posedge clk);
            #1;
            if (out_valid_a && lat_a == 0) lat_a = n;
            if (out_valid_b && lat_b == 0) lat_b = n;
        end
        check("lat_a", 32'(lat_a), 32'(el_a));
        check("lat_b", 32'(lat_b), 32'(el_b));
        check("found_a", 32'(out_found_a), 32'(f_a));
        check("inv_a", 32'(out_inverted_a), 32'(i_a));
        check("so_a", 32'(out_so_a), 32'(s_a));
        check("found_b", 32'(out_found_b), 32'(f_b));
        check("inv_b", 32'(out_inverted_b), 32'(i_b));
        check("so_b", 32'(out_so_b), 32'(s_b));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 32'(out_valid_a), 32'd1);
            check("hold_so", 32'(out_so_a), 32'(s_a));
            check("hold_found", 32'(out_found_a), 32'(f_a));
            check("hold_in_ready", 32'(in_ready_a), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("valid_drop_a", 32'(out_valid_a), 32'd0);
        check("valid_drop_b", 32'(out_valid_b), 32'd0);
        check("in_ready_back_a", 32'(in_ready_a), 32'd1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        do_reset();
        check("rst_in_ready", 32'(in_ready_a), 32'd1);
        check("rst_out_valid", 32'(out_valid_a), 32'd0);
        check("rst_found", 32'(out_found_a), 32'd0);
        check("rst_inv", 32'(out_inverted_a), 32'd0);
        check("rst_so", 32'(out_so_a), 32'd0);

        // Directed values from the corner cases of the encoding.
        run_one(32'h000000FF, 0);
        run_one(32'hFF000000, 0);
        run_one(32'h000003FC, 0);
        run_one(32'hFFFFFF00, 0);
        run_one(32'h00000102, 0);
        run_one(32'h00000000, 0);
        run_one(32'hFFFFFFFF, 0);
        run_one(32'h000000FF, 5);

        // Reset in the middle of a long search.
        in_value = 32'h00000102;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready_a), 32'd1);
        check("midrst_valid", 32'(out_valid_a), 32'd0);
        check("midrst_so", 32'(out_so_a), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_one(32'hFF000000, 0);

        // Random stimulus biased toward encodable and MVN-encodable values.
        for (int t = 0; t < 40; t++) begin
            logic [31:0] v;
            int kind;
            kind = $urandom_range(0, 3);
            v = ror32(32'($urandom_range(0, 255)), 2 * $urandom_range(0, 15));
            if (kind == 1) v = ~v;
            if (kind == 2) v = $urandom;
            run_one(v, $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
